// File: rtl/fetch_sequencer.sv
// Program-fetch controller: PC, one-cycle memory latency absorption, two-entry output/skid buffer.
// Optional FETCH_COUNT_EN adds a saturating transfer counter on port fetchcount.
module fetch_sequencer #(
    parameter logic [7:0] START_ADDR  = 8'd1,
    parameter logic [7:0] HALT_OPCODE = 8'h00
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    output logic [7:0]  pccounter,
    input  logic [7:0]  instr_in,
    output logic [7:0]  instr_out,
    output logic [7:0]  instr_pc,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    output logic        halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0] fetchcount
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t state, state_nxt;

    logic       pend;
    logic [7:0] pend_addr;
    logic       skid_valid;
    logic [7:0] skid_data;
    logic [7:0] skid_pc;

    logic       transfer, restart, flush, capture, cap_halt, cap_word, issue;
    logic       out_after_valid;
    logic [1:0] occ;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (!branch_taken && cap_halt) state_nxt = HALT;
            HALT:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        transfer        = instr_valid & ~stall;
        restart         = (state != RUN) & start;
        flush           = (state == RUN) & branch_taken;
        capture         = (state == RUN) & pend & ~branch_taken;
        cap_halt        = capture & (instr_in == HALT_OPCODE);
        cap_word        = capture & ~cap_halt;
        occ             = {1'b0, instr_valid} + {1'b0, skid_valid} + {1'b0, pend};
        issue           = (state == RUN) & ~branch_taken & ~cap_halt &
                          ((occ - {1'b0, transfer}) < 2'd2);
        // the output slot is free for a new word if it empties and no skid word refills it
        out_after_valid = transfer ? skid_valid : instr_valid;
        halted          = (state == HALT);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pccounter   <= START_ADDR;
            pend        <= 1'b0;
            pend_addr   <= '0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            skid_pc     <= '0;
        end else if (restart) begin
            pccounter   <= START_ADDR;
            pend        <= 1'b0;
            instr_valid <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (flush) begin
            pccounter   <= branch_target;
            pend        <= 1'b0;
            instr_valid <= 1'b0;
            skid_valid  <= 1'b0;
        end else begin
            pend <= issue;
            if (issue) begin
                pend_addr <= pccounter;
                pccounter <= pccounter + 8'd1;
            end
            if (transfer) begin
                instr_valid <= skid_valid;
                instr_out   <= skid_data;
                instr_pc    <= skid_pc;
                skid_valid  <= 1'b0;
            end
            if (cap_word) begin
                if (!out_after_valid) begin
                    instr_valid <= 1'b1;
                    instr_out   <= instr_in;
                    instr_pc    <= pend_addr;
                end else begin
                    skid_valid <= 1'b1;
                    skid_data  <= instr_in;
                    skid_pc    <= pend_addr;
                end
            end
        end
    end

`ifdef FETCH_COUNT_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                             fetchcount <= '0;
        else if (restart)                        fetchcount <= '0;
        else if (transfer && fetchcount != '1)   fetchcount <= fetchcount + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized stall/branch traffic,
// checked against a program-order reference (next expected address, freeze-under-stall rule).
module tb_fetch_sequencer;

    localparam logic [7:0] START  = 8'd1;
    localparam logic [7:0] HALTOP = 8'h00;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       branch_taken = 1'b0;
    logic [7:0] branch_target = 8'd0;
    logic [7:0] instr_in;
    logic [7:0] pccounter, instr_out, instr_pc;
    logic       instr_valid, halted;
`ifdef FETCH_COUNT_EN
    logic [15:0] fetchcount;
`endif

    always #5 clock = ~clock;

    fetch_sequencer #(.START_ADDR(START), .HALT_OPCODE(HALTOP)) dut (
        .clock(clock), .resetn(resetn), .start(start), .pccounter(pccounter),
        .instr_in(instr_in), .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .halted(halted)
`ifdef FETCH_COUNT_EN
        , .fetchcount(fetchcount)
`endif
    );

    logic [7:0] mem [256];
    always @(posedge clock) instr_in <= mem[pccounter];

    int          n_err = 0, n_chk = 0;
    int          nxfer = 0;
    logic [7:0]  exp_pc = START;
    logic        started = 1'b0;
    logic [15:0] fc = '0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: score any transfer against program order, apply the edge, check freeze.
    task automatic step();
        logic       xfer, br, held;
        logic [7:0] p_pc, p_out;
        xfer = instr_valid && !stall;
        br   = branch_taken && started && !halted;
        held = instr_valid && stall && !br;
        p_pc = instr_pc;
        p_out = instr_out;
        if (start && (!started || halted)) begin
            exp_pc = START; fc = '0; started = 1'b1;
        end
        if (xfer) begin
            chk("xfer_pc", {8'h0, instr_pc}, {8'h0, exp_pc});
            chk("xfer_data", {8'h0, instr_out}, {8'h0, mem[exp_pc]});
            chk("not_halt_word", {15'h0, instr_out == HALTOP}, 16'd0);
            exp_pc = exp_pc + 8'd1;
            nxfer++;
            if (fc != 16'hFFFF) fc = fc + 16'd1;
        end
        if (br) exp_pc = branch_target;
        @(posedge clock); #1;
        if (held) begin
            chk("hold_valid", {15'h0, instr_valid}, 16'd1);
            chk("hold_pc", {8'h0, instr_pc}, {8'h0, p_pc});
            chk("hold_out", {8'h0, instr_out}, {8'h0, p_out});
        end
`ifdef FETCH_COUNT_EN
        chk("fetchcount", fetchcount, fc);
`endif
    endtask

    task automatic do_reset();
        resetn = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        started = 1'b0; nxfer = 0; fc = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic run_until_pc(input logic [7:0] t, input string tag);
        int i = 0;
        while (!(instr_valid && instr_pc == t) && i < 100) begin step(); i++; end
        chk(tag, {15'h0, instr_valid && instr_pc == t}, 16'd1);
    endtask

    task automatic drain(output int bubbles);
        int i = 0;
        bubbles = 0;
        while (!(halted && !instr_valid) && i < 200) begin
            if (!instr_valid && !halted) bubbles++;
            step(); i++;
        end
        chk("drain_done", {15'h0, halted && !instr_valid}, 16'd1);
    endtask

    task automatic load_prog();
        for (int unsigned i = 0; i < 256; i++) mem[i] = 8'h55;
        mem[0] = 8'hFF;
        for (int unsigned i = 5; i <= 18; i++) mem[i] = 8'h30 + 8'(i);
        mem[1] = 8'h27; mem[2] = 8'h02; mem[3] = 8'hC8; mem[4] = 8'h2E;
        mem[10] = 8'h20; mem[19] = 8'hD0; mem[20] = HALTOP;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, {15'h0, instr_valid}, 16'd0);
        chk({tag, "_out"}, {8'h0, instr_out}, 16'd0);
        chk({tag, "_ipc"}, {8'h0, instr_pc}, 16'd0);
        chk({tag, "_pcc"}, {8'h0, pccounter}, {8'h0, START});
        chk({tag, "_halted"}, {15'h0, halted}, 16'd0);
`ifdef FETCH_COUNT_EN
        chk({tag, "_fcnt"}, fetchcount, 16'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bub;

        // Straight-line program, no stall: latency, throughput, halt.
        load_prog();
        resetn = 1'b0;
        #12;
        check_reset_values("rst");
        do_reset();
        pulse_start();
        chk("lat_n_valid", {15'h0, instr_valid}, 16'd0);
        step();
        chk("lat_n1_valid", {15'h0, instr_valid}, 16'd0);
        chk("lat_n1_pcc", {8'h0, pccounter}, 16'd2);
        step();
        chk("lat_n2_valid", {15'h0, instr_valid}, 16'd1);
        chk("lat_n2_pc", {8'h0, instr_pc}, 16'd1);
        chk("lat_n2_out", {8'h0, instr_out}, 16'h27);
        drain(bub);
        chk("t1_count", 16'(nxfer), 16'd19);
        chk("t1_bubbles", 16'(bub), 16'd0);
        chk("t1_halted", {15'h0, halted}, 16'd1);
        chk("t1_pcc_after_halt", {8'h0, pccounter}, 16'd21);

        // Five-cycle stall on the word at address 4.
        do_reset();
        pulse_start();
        run_until_pc(8'd4, "t2_reach4");
        stall = 1'b1;
        repeat (5) step();
        chk("t2_stall_out", {8'h0, instr_out}, 16'h2E);
        chk("t2_stall_pc", {8'h0, instr_pc}, 16'd4);
        stall = 1'b0;
        drain(bub);
        chk("t2_count", 16'(nxfer), 16'd19);

        // Branch to 10 while address 3 is being delivered.
        do_reset();
        pulse_start();
        run_until_pc(8'd3, "t3_reach3");
        branch_taken = 1'b1; branch_target = 8'd10;
        step();
        branch_taken = 1'b0;
        chk("t3_flush_valid", {15'h0, instr_valid}, 16'd0);
        chk("t3_pcc", {8'h0, pccounter}, 16'd10);
        step();
        chk("t3_gap_valid", {15'h0, instr_valid}, 16'd0);
        step();
        chk("t3_tgt_valid", {15'h0, instr_valid}, 16'd1);
        chk("t3_tgt_pc", {8'h0, instr_pc}, 16'd10);
        chk("t3_tgt_out", {8'h0, instr_out}, 16'h20);
        drain(bub);
        chk("t3_count", 16'(nxfer), 16'd13);

        // Branch on the edge that captures the halt word.
        do_reset();
        pulse_start();
        run_until_pc(8'd19, "t4_reach19");
        branch_taken = 1'b1; branch_target = 8'd1;
        step();
        branch_taken = 1'b0;
        chk("t4_no_halt", {15'h0, halted}, 16'd0);
        step(); step();
        chk("t4_resume_valid", {15'h0, instr_valid}, 16'd1);
        chk("t4_resume_pc", {8'h0, instr_pc}, 16'd1);
        drain(bub);
        chk("t4_count", 16'(nxfer), 16'd38);

        // No halt word anywhere: wrap at 255, then random stall/branch traffic.
        for (int unsigned i = 0; i < 256; i++) mem[i] = 8'h80 | 8'(i * 37);
        do_reset();
        pulse_start();
        repeat (3) step();
        branch_taken = 1'b1; branch_target = 8'd254;
        step();
        branch_taken = 1'b0;
        chk("t5_pcc254", {8'h0, pccounter}, 16'd254);
        step();
        chk("t5_pcc255", {8'h0, pccounter}, 16'd255);
        step();
        chk("t5_pcc_wrap", {8'h0, pccounter}, 16'd0);
        chk("t5_pc254", {8'h0, instr_pc}, 16'd254);
        step();
        chk("t5_pc255", {8'h0, instr_pc}, 16'd255);
        step();
        chk("t5_pc0", {8'h0, instr_pc}, 16'd0);
        step();
        chk("t5_pc1", {8'h0, instr_pc}, 16'd1);
        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom_range(0, 99) < 40);
            branch_taken  = ($urandom_range(0, 99) < 4);
            branch_target = 8'($urandom);
            step();
        end
        branch_taken = 1'b0;

        // Fill output and skid, then reset asynchronously mid-cycle.
        stall = 1'b0;
        branch_taken = 1'b1; branch_target = 8'd50;
        step();
        branch_taken = 1'b0;
        step(); step();
        stall = 1'b1;
        repeat (3) step();
        chk("t6_full_pc", {8'h0, instr_pc}, 16'd50);
        chk("t6_full_valid", {15'h0, instr_valid}, 16'd1);
        #3 resetn = 1'b0;
        #1;
        check_reset_values("t6_async");
        stall = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        started = 1'b0; nxfer = 0; fc = '0;
        pulse_start();
        step(); step();
        chk("t6_restart_valid", {15'h0, instr_valid}, 16'd1);
        chk("t6_restart_pc", {8'h0, instr_pc}, {8'h0, START});
        chk("t6_restart_out", {8'h0, instr_out}, {8'h0, mem[START]});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
